seg7_scan_display: RTL and testbench
====================================

// Module: seg7_scan_display
// PURPOSE
//   Downstream display stage for the Basys3 4-bit ALU top. Latches a 16-bit nibble
//   word, {result, opcode, B, A}, on a valid strobe, then time-multiplexes it as four
//   hex digits on the Basys3 common-anode 7-segment display.
//   Each digit slot begins with a ghost-suppression blanking interval, then drives
//   the digit. Sits beside the LED drive in the board top and shares the 100 MHz clock.
// PARAMETERS
//   REFRESH_DIV   100_000  clock cycles per digit slot; 4 slots form a frame; min 4
//   BLANK_CYCLES  2_000    cycles at the start of each slot with all anodes off; 1..REFRESH_DIV-1
// PORTS
//   clk          in   1   system clock, 100 MHz on the board
//   rst_n        in   1   asynchronous, active-low reset
//   load_valid   in   1   strobe; captures digits_in and dp_in on a rising clk edge while high
//   digits_in    in   16  digit3..0 = [15:12],[11:8],[7:4],[3:0]; digit0 is the rightmost
//   dp_in        in   4   decimal-point request per digit; 1 = lit
//   blank_in     in   4   per-digit blank request; 1 = digit dark; sampled continuously
//   an           out  4   anode enables, active-low; an[0] is the rightmost digit
//   seg          out  7   {g,f,e,d,c,b,a}, active-low
//   dp           out  1   decimal point, active-low
//   frame_tick   out  1   one-cycle pulse when the slot index wraps from 3 to 0
// BEHAVIOUR
//   Reset (async assert, takes effect immediately, mid-operation included):
//     an=4'hF, seg=7'h7F, dp=1, frame_tick=0; shadow regs=0; slot counter=0;
//     slot index=0; FSM=BLANK. Release is synchronous to clk.
//   Capture: while load_valid is high at an edge, the shadow regs take digits_in/dp_in.
//     The shadow regs hold their value otherwise. There is no backpressure; every
//     strobe is accepted.
//   Slot timing: cnt counts 0..REFRESH_DIV-1 and then wraps. When cnt wraps, the slot
//     index advances 0->1->2->3->0.
//   Display register: at cnt==0, it loads the current slot's nibble and dp bit from
//     the shadow regs. A capture therefore never changes a digit mid-slot. A capture
//     at the same edge as cnt==0 is not visible until the next slot.
//   FSM, all outputs registered:
//     BLANK: an=4'hF, seg=7'h7F, dp=1. Goes to DRIVE after BLANK_CYCLES cycles,
//       when cnt==BLANK_CYCLES-1.
//     DRIVE: an = ~(4'b0001<<idx); seg = hex(nibble); dp = ~dp_bit. Goes to BLANK
//       when cnt wraps.
//     DRIVE with blank_in[idx]=1: an=4'hF, seg=7'h7F, dp=1. Slot timing is unchanged.
//   Latency: outputs reflect the FSM state one cycle after the cnt value that
//     selects that state.
//   Hex table (seg): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03
//     C=46 d=21 E=06 F=0E (hex, 7-bit).
//   frame_tick: high for exactly the one cycle after the edge where the slot index
//     goes from 3 to 0.
//   At most one anode is low in any cycle. There is never an overlap between slots.
// TESTING  (REFRESH_DIV=8, BLANK_CYCLES=2)
//   Reset asserted mid-DRIVE -> an=F, seg=7F, dp=1 in the same cycle, with no clk
//     edge. After release, a full BLANK precedes digit0.
//   load digits_in=16'h3A07, dp_in=0 -> slots show an=E seg=78, an=D seg=40,
//     an=B seg=08, an=7 seg=30, each for 6 cycles after 2 blank cycles.
//   Strobe 16'hFFFF mid-slot 1 -> slot 1 keeps its old digit until its end;
//     slot 2 shows seg=0E.
//   blank_in=4'b0101, dp_in=4'b0010 -> digits 0 and 2 are dark. Digit 1 shows dp=0.
//     Cadence is unchanged.
//   Run 3 frames -> frame_tick pulses every 32 cycles, 1 cycle wide.
//   Any cycle -> $countones(~an) <= 1. All 16 hex codes match the table.

Source files
------------

// File: rtl/seg7_scan_display.sv
// Latches a {result, opcode, B, A} nibble word and scans it across the four
// common-anode 7-segment digits, with a blanking interval at the start of every slot.
module seg7_scan_display #(
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 2_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {
        BLANK,
        DRIVE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   shadow_digits;
    logic [3:0]    shadow_dp;
    logic [3:0]    cur_nibble;
    logic          cur_dp;
    logic [3:0]    nibble_next;
    logic          dp_bit_next;
    logic          cnt_wrap;
    logic          slot_start;
    logic          blank_end;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;
    logic          frame_tick_next;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign cnt_wrap        = (cnt == CW'(REFRESH_DIV - 1));
    assign slot_start      = (cnt == '0);
    assign blank_end       = (cnt == CW'(BLANK_CYCLES - 1));
    assign frame_tick_next = cnt_wrap && (idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt_wrap) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_digits <= 16'h0000;
            shadow_dp     <= 4'h0;
        end else if (load_valid) begin
            shadow_digits <= digits_in;
            shadow_dp     <= dp_in;
        end
    end

    // The digit for a slot is frozen at cnt==0 so a capture never tears a digit mid-slot.
    always_comb begin
        nibble_next = cur_nibble;
        dp_bit_next = cur_dp;
        if (slot_start) begin
            nibble_next = shadow_digits[{idx, 2'b00} +: 4];
            dp_bit_next = shadow_dp[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_nibble <= 4'h0;
            cur_dp     <= 1'b0;
        end else begin
            cur_nibble <= nibble_next;
            cur_dp     <= dp_bit_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BLANK:   if (blank_end) state_next = DRIVE;
            DRIVE:   if (cnt_wrap)  state_next = BLANK;
            default: state_next = BLANK;
        endcase
    end

    // idx only moves on a wrap, which always lands in BLANK, so idx is stable here.
    always_comb begin
        an_next  = 4'hF;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (state_next == DRIVE && !blank_in[idx]) begin
            an_next  = ~(4'b0001 << idx);
            seg_next = hex7(nibble_next);
            dp_next  = ~dp_bit_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_next;
            an         <= an_next;
            seg        <= seg_next;
            dp         <= dp_next;
            frame_tick <= frame_tick_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with an 8-cycle slot and 2 blank cycles,
// i.e. a 32-cycle frame; sample k is taken on the falling edge after rising edge k.
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;
    int k        = 0;
    bit track    = 1'b0;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      dpv;
        logic [3:0]      blankv;
        logic [3:0][3:0] ean;
        logic [3:0][6:0] eseg;
        logic [3:0]      edp;
    } vec_t;

    vec_t vecs[7];

    seg7_scan_display #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load_valid(load_valid),
        .digits_in(digits_in),
        .dp_in(dp_in),
        .blank_in(blank_in),
        .an(an),
        .seg(seg),
        .dp(dp),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] ean,
                               input logic [6:0] eseg, input logic edp);
        checks++;
        if (an !== ean) begin
            failures++;
            $display("[TB] FAIL %s an: got %h expected %h (k=%0d)", name, an, ean, k);
        end
        checks++;
        if (seg !== eseg) begin
            failures++;
            $display("[TB] FAIL %s seg: got %h expected %h (k=%0d)", name, seg, eseg, k);
        end
        checks++;
        if (dp !== edp) begin
            failures++;
            $display("[TB] FAIL %s dp: got %b expected %b (k=%0d)", name, dp, edp, k);
        end
    endtask

    // Every tracked cycle checks the one-anode rule and the frame_tick position.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        k++;
        if (track) begin
            checkBit("one_anode", ($countones(~an) <= 1), 1'b1);
            checkBit("frame_tick", frame_tick, ((k % 32) == 0) && (k > 0));
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p);
        digits_in  = d;
        dp_in      = p;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic runFrame(input int vi, input vec_t v);
        int s;
        int ph;
        for (int c = 0; c < 32; c++) begin
            tick();
            s  = (k / 8) % 4;
            ph = k % 8;
            if (ph < 2)
                checkOutput($sformatf("v%0d_blank", vi), 4'hF, 7'h7F, 1'b1);
            else
                checkOutput($sformatf("v%0d_slot%0d", vi, s), v.ean[s], v.eseg[s], v.edp[s]);
        end
    endtask

    initial begin
        int ft_count;
        vecs[0] = '{16'h3A07, 4'h0, 4'h0, {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'h30, 7'h08, 7'h40, 7'h78}, 4'hF};
        vecs[1] = '{16'h5C81, 4'b0010, 4'b0101, {4'h7, 4'hF, 4'hD, 4'hF},
                    {7'h12, 7'h7F, 7'h00, 7'h7F}, 4'b1101};
        vecs[2] = '{16'h3210, 4'h0, 4'h0, {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'h30, 7'h24, 7'h79, 7'h40}, 4'hF};
        vecs[3] = '{16'h7654, 4'h0, 4'h0, {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'h78, 7'h02, 7'h12, 7'h19}, 4'hF};
        vecs[4] = '{16'hBA98, 4'h0, 4'h0, {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'h03, 7'h08, 7'h10, 7'h00}, 4'hF};
        vecs[5] = '{16'hFEDC, 4'h0, 4'h0, {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'h0E, 7'h06, 7'h21, 7'h46}, 4'hF};
        vecs[6] = '{16'h8888, 4'hF, 4'h0, {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'h00, 7'h00, 7'h00, 7'h00}, 4'h0};

        rst_n      = 1'b1;
        load_valid = 1'b0;
        digits_in  = 16'h0000;
        dp_in      = 4'h0;
        blank_in   = 4'h0;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset", 4'hF, 7'h7F, 1'b1);
        checkBit("reset_frame_tick", frame_tick, 1'b0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
        track = 1'b1;

        // Load during slot 3 of a frame, then check the whole following frame.
        for (int v = 0; v < 7; v++) begin
            while ((k % 32) != 28) tick();
            applyStimulus(vecs[v].digits, vecs[v].dpv);
            while ((k % 32) != 0) tick();
            blank_in = vecs[v].blankv;
            runFrame(v, vecs[v]);
        end

        // Mid-slot capture must not disturb the digit already on display.
        blank_in = 4'h0;
        while ((k % 32) != 28) tick();
        applyStimulus(16'h3A07, 4'h0);
        while ((k % 32) != 11) tick();
        applyStimulus(16'hFFFF, 4'h0);
        checkOutput("midslot_keep_a", 4'hD, 7'h40, 1'b1);
        while ((k % 32) != 15) tick();
        checkOutput("midslot_keep_b", 4'hD, 7'h40, 1'b1);
        while ((k % 32) != 18) tick();
        checkOutput("next_slot_new", 4'hB, 7'h0E, 1'b1);

        // A capture on the cnt==0 edge only shows up from the next slot.
        while ((k % 32) != 24) tick();
        applyStimulus(16'h1111, 4'h0);
        tick();
        checkOutput("same_edge_old", 4'h7, 7'h0E, 1'b1);
        while ((k % 32) != 2) tick();
        checkOutput("same_edge_new", 4'hE, 7'h79, 1'b1);

        // Asynchronous reset in the middle of a driven slot.
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 4'hF, 7'h7F, 1'b1);
        checkBit("async_reset_frame_tick", frame_tick, 1'b0);
        track = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        k     = 0;
        track = 1'b1;
        checkOutput("post_reset_k0", 4'hF, 7'h7F, 1'b1);
        tick();
        checkOutput("post_reset_blank", 4'hF, 7'h7F, 1'b1);
        tick();
        checkOutput("post_reset_digit0", 4'hE, 7'h40, 1'b1);

        ft_count = 0;
        for (int c = 0; c < 94; c++) begin
            tick();
            if (frame_tick) ft_count++;
        end
        checks++;
        if (ft_count != 3) begin
            failures++;
            $display("[TB] FAIL frame_tick_count: got %0d expected 3", ft_count);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] timeout");
    end

endmodule
